safe_softmax_exp2_pipe: RTL
===========================

SAFE_SOFTMAX_EXP2_PIPE -- requirements
Module: safe_softmax_exp2_pipe

Interface
REQ-001 Parameter D_W, default 16, meaning data width; only 16 and 8 are legal; FRAC = D_W-3 fractional bits.
REQ-002 Parameter N_CH, default 4, meaning number of parallel lanes (1..16).
REQ-003 I_CLK  input  1  clock; all state updates on rising edge.
REQ-004 I_RST_N  input  1  one clock; reset is asynchronous and active-low.
REQ-005 I_VALID  input  1  upstream beat valid.
REQ-006 O_READY  output  1  block can accept a beat this cycle.
REQ-007 I_X  input  N_CH*D_W  packed lanes; lane k = I_X[k*D_W +: D_W], unsigned magnitude of negative exponent, x = -I_X; int part = top 3 bits, frac f = low FRAC bits.
REQ-008 O_VALID  output  1  output beat valid.
REQ-009 I_READY  input  1  downstream accepts output beat.
REQ-010 O_DATA  output  N_CH*D_W  packed lanes of 2^x, unsigned Q2.FRAC (1.0 = 2^FRAC).

Function
REQ-011 The block SHALL compute per lane y = 2^-f >> int, using a 3-segment linear approximation of 2^-f.
REQ-012 Segment select SHALL be: f <= T1 -> seg0; T1 < f < T2 -> seg1; f >= T2 -> seg2; T1 = 1930, T2 = 6026 (D_W=16); T1 = 7, T2 = 23 (D_W=8).
REQ-013 Mantissa SHALL be m = K - ((S*f) >> FRAC); D_W=16: (K,S) = seg0 (8192,5678), seg1 (7800,4015), seg2 (6935,2839); D_W=8: seg0 (32,22), seg1 (30,16), seg2 (27,11).
REQ-014 Product S*f SHALL be computed at full width (2*FRAC+1 bits) with no overflow; m SHALL never exceed 2^FRAC nor go negative for any legal f.
REQ-015 Output SHALL be y = m >> int (int 0..7), zero-filled, lane results independent.
REQ-016 Pipeline SHALL be 3 register stages: S1 capture I_X plus segment select; S2 multiply/subtract; S3 shift and output register; latency 3 cycles from accepted beat to O_VALID with no stall.
REQ-017 Beat accepted when I_VALID & O_READY; beat leaves when O_VALID & I_READY.
REQ-018 O_READY SHALL equal ~O_VALID | I_READY (combinational); all stages advance together when O_READY is 1, hold otherwise.
REQ-019 Bubbles (invalid stages) SHALL propagate with valid=0; throughput 1 beat/cycle when I_READY is held 1.
REQ-020 While O_VALID=1 and I_READY=0, O_DATA and O_VALID SHALL remain stable.
REQ-021 I_X SHALL be ignored in cycles where no beat is accepted; data register contents of invalid stages are don't-care internally but O_DATA SHALL hold its last value.

Reset
REQ-022 On I_RST_N low, all stage valid bits and O_VALID SHALL clear to 0 immediately, O_DATA SHALL be 0.
REQ-023 In-flight beats SHALL be discarded by reset; first output after reset release comes 3 cycles after first accepted beat.
REQ-024 O_READY SHALL be 1 during and immediately after reset.

Configuration
REQ-025 Macro SOFTMAX_EXP2_ROUND_EN defined: (S*f) >> FRAC and m >> int SHALL round half-up (add bit just below the cut).
REQ-026 Macro SOFTMAX_EXP2_ROUND_EN undefined: both shifts SHALL truncate; no other behaviour changes, latency identical.

Verification
REQ-027 D_W=16, lane0 I_X=0x0000 -> O_DATA lane0 = 8192, 3 cycles after acceptance.
REQ-028 I_X=0x2000 (x=-1.0) -> 4096; I_X=0x1000 (x=-0.5, seg1) -> 5792 with ROUND_EN, 5793 without.
REQ-029 I_X=0xFFFF (int 7, f=8191, seg2) -> 32 both builds; I_X=1930 -> seg0, I_X=1931 -> seg1 (boundary check vs reference model).
REQ-030 Stream 8 beats with I_READY=0 from cycle 4 for 5 cycles -> O_READY=0 while stalled, O_DATA stable, no beat lost or duplicated, order preserved.
REQ-031 Assert I_RST_N low with 2 beats in flight -> O_VALID=0 at once, O_DATA=0, no stale beat emerges after release.
REQ-032 Exhaustive sweep D_W=8, N_CH=4, all 256 values per lane -> bit-exact vs golden model; max error vs true 2^x within 2 LSB before shift.

Source files
------------

// File: rtl/safe_softmax_exp2_pipe.sv
// safe_softmax_exp2_pipe: per-lane y = 2^-x using a 3-segment linear mantissa, 3-stage valid/ready pipe.
// Build option: define SOFTMAX_EXP2_ROUND_EN for round-half-up on both shifts (default truncates).
module safe_softmax_exp2_pipe #(
    parameter int D_W  = 16,
    parameter int N_CH = 4
) (
    input  logic                I_CLK,
    input  logic                I_RST_N,
    input  logic                I_VALID,
    output logic                O_READY,
    input  logic [N_CH*D_W-1:0] I_X,
    output logic                O_VALID,
    input  logic                I_READY,
    output logic [N_CH*D_W-1:0] O_DATA
);
    localparam int FRAC = D_W - 3;
    localparam int PW   = 2*FRAC + 1;
    localparam int MW   = FRAC + 2;
`ifdef SOFTMAX_EXP2_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif
    localparam bit IS16 = (D_W == 16);

    localparam logic [FRAC-1:0] T1 = FRAC'(IS16 ? 1930 : 7);
    localparam logic [FRAC-1:0] T2 = FRAC'(IS16 ? 6026 : 23);
    localparam logic [MW-1:0]   K0 = MW'(IS16 ? 8192 : 32);
    localparam logic [MW-1:0]   K1 = MW'(IS16 ? 7800 : 30);
    localparam logic [MW-1:0]   K2 = MW'(IS16 ? 6935 : 27);
    localparam logic [FRAC-1:0] S0 = FRAC'(IS16 ? 5678 : 22);
    localparam logic [FRAC-1:0] S1 = FRAC'(IS16 ? 4015 : 16);
    localparam logic [FRAC-1:0] S2 = FRAC'(IS16 ? 2839 : 11);
    localparam logic [PW-1:0]   P_HALF = ROUND ? (PW'(1) << (FRAC-1)) : '0;

    typedef enum logic [1:0] {SEG0, SEG1, SEG2} seg_e;

    logic                s1_valid;
    logic                s2_valid;
    logic [2:0]          s1_int [N_CH];
    logic [FRAC-1:0]     s1_f   [N_CH];
    seg_e                s1_seg [N_CH];
    logic [2:0]          s2_int [N_CH];
    logic [MW-1:0]       s2_m   [N_CH];

    logic [2:0]          int_d  [N_CH];
    logic [FRAC-1:0]     f_d    [N_CH];
    seg_e                seg_d  [N_CH];
    logic [MW-1:0]       m_d    [N_CH];
    logic [N_CH*D_W-1:0] y_d;

    // Whole pipe moves as one; a held output beat freezes every stage behind it.
    assign O_READY = ~O_VALID | I_READY;

    always_comb begin : seg_select
        for (int k = 0; k < N_CH; k++) begin
            int_d[k] = I_X[k*D_W + FRAC +: 3];
            f_d[k]   = I_X[k*D_W +: FRAC];
            seg_d[k] = SEG1;
            if (f_d[k] <= T1)
                seg_d[k] = SEG0;
            else if (f_d[k] >= T2)
                seg_d[k] = SEG2;
        end
    end

    always_comb begin : mantissa
        logic [MW-1:0]   k_sel;
        logic [FRAC-1:0] s_sel;
        logic [PW-1:0]   prod;
        k_sel = K0;
        s_sel = S0;
        prod  = '0;
        for (int k = 0; k < N_CH; k++) begin
            k_sel = K0;
            s_sel = S0;
            case (s1_seg[k])
                SEG1:    begin k_sel = K1; s_sel = S1; end
                SEG2:    begin k_sel = K2; s_sel = S2; end
                default: ;
            endcase
            // Full-width product, so the largest S*f cannot wrap before the cut.
            prod   = PW'(s_sel) * PW'(s1_f[k]) + P_HALF;
            m_d[k] = k_sel - MW'(prod >> FRAC);
        end
    end

    always_comb begin : int_shift
        logic [MW-1:0] half;
        half = '0;
        y_d  = '0;
        for (int k = 0; k < N_CH; k++) begin
            half = '0;
            if (ROUND && s2_int[k] != 3'd0)
                half = MW'(1) << (s2_int[k] - 3'd1);
            y_d[k*D_W +: D_W] = D_W'((s2_m[k] + half) >> s2_int[k]);
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            O_VALID  <= 1'b0;
            O_DATA   <= '0;
            for (int k = 0; k < N_CH; k++) begin
                s1_int[k] <= '0;
                s1_f[k]   <= '0;
                s1_seg[k] <= SEG0;
                s2_int[k] <= '0;
                s2_m[k]   <= '0;
            end
        end else if (O_READY) begin
            s1_valid <= I_VALID;
            s2_valid <= s1_valid;
            O_VALID  <= s2_valid;
            if (I_VALID) begin
                for (int k = 0; k < N_CH; k++) begin
                    s1_int[k] <= int_d[k];
                    s1_f[k]   <= f_d[k];
                    s1_seg[k] <= seg_d[k];
                end
            end
            if (s1_valid) begin
                for (int k = 0; k < N_CH; k++) begin
                    s2_int[k] <= s1_int[k];
                    s2_m[k]   <= m_d[k];
                end
            end
            if (s2_valid)
                O_DATA <= y_d;
        end
    end

endmodule
